// File: rtl/ic_shl_cmp_skolem_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ic_shl_cmp_skolem_seq_if
// Description : Request/response streaming bundle for the shift-left Skolem
//               witness generator.
//               Request  : in_valid / in_ready / in_s / in_t / in_op
//               Response : out_valid / out_ready / out_x / out_sat
//               The master modport belongs to the producer of requests and the
//               consumer of results. The slave modport belongs to the
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface ic_shl_cmp_skolem_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_s;
  logic [W-1:0] in_t;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic         out_sat;

  modport master (
    output in_valid, in_s, in_t, in_op, out_ready,
    input  in_ready, out_valid, out_x, out_sat
  );

  modport slave (
    input  in_valid, in_s, in_t, in_op, out_ready,
    output in_ready, out_valid, out_x, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/ic_shl_cmp_skolem_seq.sv
`default_nettype none
// ============================================================================
// Module      : ic_shl_cmp_skolem_seq
// Description : Sequential Skolem-witness generator for shift-left
//               invertibility conditions. For captured operands s, t and a
//               comparison op, the block finds the smallest x in 0..W with
//               (s << x) op t, using one candidate per clock. It reports
//               out_sat=0 and out_x=0 when no such x exists.
//               op: 00 signed >=, 01 signed >, 10 unsigned >=, 11 unsigned >
// Ports       : clk   - clock; all state changes on the rising edge
//               rst_n - asynchronous active-low reset, released synchronously
//               bus   - ic_shl_cmp_skolem_seq_if.slave (request/response)
// Option      : SKOLEM_EARLY_EXIT_EN - a failing search ends as soon as the
//               shifted operand becomes zero. Every later candidate is also
//               zero, so results do not change; only the latency does.
// Revision    : 1.0 - initial release
// ============================================================================
module ic_shl_cmp_skolem_seq #(
  parameter int W = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  ic_shl_cmp_skolem_seq_if.slave     bus
);

  // Candidate counter width. It must hold the value W itself.
  localparam int CW = $clog2(W + 1);

  localparam logic [CW-1:0] C_K_LAST = CW'(W);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] OP_SGE = 2'b00;
  localparam logic [1:0] OP_SGT = 2'b01;
  localparam logic [1:0] OP_UGE = 2'b10;
  localparam logic [1:0] OP_UGT = 2'b11;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  logic [W-1:0]  r_s;
  logic [W-1:0]  r_t;
  logic [1:0]    r_op;
  logic [CW-1:0] r_k;
  logic [W-1:0]  r_x;
  logic          r_sat;

  logic [W-1:0]  w_shifted;
  logic          w_cond;
  logic          w_exhausted;
  logic          w_accept;
  logic          w_release;

  // --------------------------------------------------------------------------
  // Candidate evaluation: W-bit shift with truncation, then the selected
  // comparison.
  // --------------------------------------------------------------------------
  always_comb begin
    w_shifted = r_s << r_k;
    w_cond    = 1'b0;
    case (r_op)
      OP_SGE:  w_cond = $signed(w_shifted) >= $signed(r_t);
      OP_SGT:  w_cond = $signed(w_shifted) >  $signed(r_t);
      OP_UGE:  w_cond = w_shifted >= r_t;
      OP_UGT:  w_cond = w_shifted >  r_t;
      default: w_cond = 1'b0;
    endcase
  end

  // The search gives up at the last candidate. With early exit it also stops
  // once the shifted value is zero, because all larger shifts are zero too.
  always_comb begin
`ifdef SKOLEM_EARLY_EXIT_EN
    w_exhausted = (r_k == C_K_LAST) || (w_shifted == '0);
`else
    w_exhausted = (r_k == C_K_LAST);
`endif
  end

  assign w_accept  = (r_state == ST_IDLE) && bus.in_valid;
  assign w_release = (r_state == ST_DONE) && bus.out_ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (w_cond || w_exhausted) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Returning to IDLE first means no request is accepted on the same
        // edge as the result handshake.
        if (w_release) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE:   bus.in_ready  = 1'b1;
      ST_DONE:   bus.out_valid = 1'b1;
      default: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
      end
    endcase
  end

  assign bus.out_x   = r_x;
  assign bus.out_sat = r_sat;

  // --------------------------------------------------------------------------
  // Datapath: operand capture, candidate counter and result registers.
  // Operands are written only on accept, so later input changes are ignored.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_t   <= '0;
      r_op  <= '0;
      r_k   <= '0;
      r_x   <= '0;
      r_sat <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_s  <= bus.in_s;
            r_t  <= bus.in_t;
            r_op <= bus.in_op;
            r_k  <= '0;
          end
        end
        ST_SEARCH: begin
          if (w_cond) begin
            r_x   <= W'(r_k);
            r_sat <= 1'b1;
          end else if (w_exhausted) begin
            r_x   <= '0;
            r_sat <= 1'b0;
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        default: begin
          // DONE holds the result stable until the consumer takes it.
        end
      endcase
    end
  end

endmodule
`default_nettype wire
